// File: rtl/row_assemble_fifo.sv
// Serial-in, parallel-out row assembler: packs DEPTH words from a valid/ready stream into one row.
// Optional macro ROW_PASSTHRU_EN lets a new row start on the release cycle, removing the per-row bubble.
module row_assemble_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BITS  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [BITS-1:0]              in_data,
    output logic                         in_ready,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BITS-1:0]              out_row [DEPTH-1:0],
    output logic [$clog2(DEPTH+1)-1:0]   out_len
);

    localparam int unsigned LEN_W = $clog2(DEPTH + 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t              r_state;
    logic [BITS-1:0]     r_row [DEPTH-1:0];
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    r_len;
    logic                w_accept;
    logic [LEN_W-1:0]    w_k;

`ifdef ROW_PASSTHRU_EN
    assign in_ready = (r_state == S_FILL) || ((r_state == S_FULL) && out_ready);
`else
    assign in_ready = (r_state == S_FILL);
`endif
    assign out_valid = (r_state == S_FULL);
    assign w_accept  = in_valid && in_ready;
    // Words held in the row if this cycle's accept (if any) completes.
    assign w_k       = r_cnt + LEN_W'(w_accept);

    assign out_row = r_row;
    assign out_len = r_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_row[i] <= '0;
            end
            r_cnt   <= '0;
            r_len   <= '0;
            r_state <= S_FILL;
        end else if (r_state == S_FILL) begin
            if (w_accept) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (LEN_W'(i) == r_cnt) begin
                        r_row[i] <= in_data;
                    end
                end
                r_cnt <= w_k;
            end
            if (w_accept && (r_cnt == LEN_W'(DEPTH - 1))) begin
                r_state <= S_FULL;
                r_len   <= LEN_W'(DEPTH);
            end else if (flush && (w_k != '0)) begin
                r_state <= S_FULL;
                r_len   <= w_k;
            end
        end else begin
            // Release clears storage so a later short row reads zero past its length.
            if (out_ready) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_row[i] <= '0;
                end
                r_cnt   <= '0;
                r_len   <= '0;
                r_state <= S_FILL;
`ifdef ROW_PASSTHRU_EN
                if (in_valid) begin
                    r_row[0] <= in_data;
                    r_cnt    <= LEN_W'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_row_assemble_fifo.sv
// Bench for row_assemble_fifo: directed scenarios plus random traffic against a queue-based row model.
module tb_row_assemble_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned BITS  = 64;
    localparam int unsigned LEN_W = $clog2(DEPTH + 1);
`ifdef ROW_PASSTHRU_EN
    localparam bit PASS = 1'b1;
`else
    localparam bit PASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [BITS-1:0]   in_data;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [BITS-1:0]   out_row [DEPTH-1:0];
    logic [LEN_W-1:0]  out_len;

    row_assemble_fifo #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    int unsigned     vectors = 0;
    int unsigned     errors  = 0;
    logic [BITS-1:0] m_q [$];
    bit              m_full  = 1'b0;
    bit              m_known = 1'b0;
    bit              last_ov;

    task automatic chk(input string name, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference: a row is an ordered list of accepted words; positions past its end read zero.
    task automatic check_outputs();
        logic [BITS-1:0] exp_w;
        chk("in_ready", in_ready, (!m_full || (PASS && out_ready)));
        chk("out_valid", out_valid, m_full);
        chk("out_len", out_len, m_full ? m_q.size() : 0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp_w = (i < m_q.size()) ? m_q[i] : '0;
            chk($sformatf("out_row[%0d]", i), out_row[i], exp_w);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [BITS-1:0] d,
                              input bit f, input bit ordy);
        if (r) begin
            m_q.delete();
            m_full  = 1'b0;
            m_known = 1'b1;
        end else if (!m_full) begin
            if (v) m_q.push_back(d);
            if (m_q.size() == DEPTH) m_full = 1'b1;
            else if (f && m_q.size() > 0) m_full = 1'b1;
        end else if (ordy) begin
            m_q.delete();
            m_full = 1'b0;
            if (PASS && v) m_q.push_back(d);
        end
    endtask

    // One clock: drive at the falling edge, check before the rising edge, advance the model.
    task automatic tick(input bit r, input bit v, input logic [BITS-1:0] d,
                        input bit f, input bit ordy);
        rst = r; in_valid = v; in_data = d; flush = f; out_ready = ordy;
        #1;
        last_ov = out_valid;
        if (m_known) check_outputs();
        @(posedge clk);
        model_edge(r, v, d, f, ordy);
        @(negedge clk);
    endtask

    initial begin
        int first_ov;
        int second_ov;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

        tick(1, 0, 0, 0, 0);
        tick(1, 1, 64'hdead, 1, 1);

        // Full row 0x10..0x17, held while the consumer stalls.
        for (int i = 0; i < 8; i++) tick(0, 1, 64'h10 + 64'(i), 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 64'hbad0 + 64'(i), 0, 0);
        chk("row_first", out_row[0], 64'h10);
        chk("row_last", out_row[7], 64'h17);
        chk("row_len", {60'd0, out_len}, 64'd8);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);

        // Partial row closed by flush, then flush on an empty row.
        tick(0, 1, 64'hA, 0, 0);
        tick(0, 1, 64'hB, 0, 0);
        tick(0, 1, 64'hC, 0, 0);
        tick(0, 0, 0, 1, 0);
        chk("flush_len", {60'd0, out_len}, 64'd3);
        chk("flush_pad", out_row[3], 64'd0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);

        // Flush together with the 5th word, then with the 8th.
        for (int i = 0; i < 4; i++) tick(0, 1, 64'h40 + 64'(i), 0, 0);
        tick(0, 1, 64'h44, 1, 0);
        chk("flush5_len", {60'd0, out_len}, 64'd5);
        chk("flush5_word", out_row[4], 64'h44);
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) tick(0, 1, 64'h50 + 64'(i), 0, 0);
        tick(0, 1, 64'h57, 1, 0);
        chk("flush8_len", {60'd0, out_len}, 64'd8);
        tick(0, 0, 0, 0, 1);

        // Reset in the middle of a row, then a clean row.
        for (int i = 0; i < 4; i++) tick(0, 1, 64'h60 + 64'(i), 0, 0);
        tick(1, 1, 64'h99, 0, 0);
        chk("rst_mid_row0", out_row[0], 64'd0);
        for (int i = 0; i < 8; i++) tick(0, 1, 64'h70 + 64'(i), 0, 0);
        tick(0, 0, 0, 0, 1);

        // Streaming throughput: spacing between completed rows.
        tick(1, 0, 0, 0, 0);
        first_ov  = -1;
        second_ov = -1;
        for (int c = 0; c < 20; c++) begin
            tick(0, 1, 64'h100 + 64'(c), 0, 1);
            if (last_ov) begin
                if (first_ov < 0) first_ov = c;
                else if (second_ov < 0) second_ov = c;
            end
        end
        chk("first_row_cycle", 64'(first_ov), 64'(DEPTH));
        chk("row_interval", 64'(second_ov - first_ov), 64'(DEPTH + (PASS ? 0 : 1)));

        // Random traffic.
        tick(1, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            tick(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 7),
                 {$urandom, $urandom},
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
